// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU writeback path.
package cpu_pkg;

  localparam int BUS_WIDTH      = 7;
  localparam int DATA_WIDTH     = BUS_WIDTH + 1;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] address;
    logic signed [BUS_WIDTH:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU  = 1'b0,
    WB_SRC_LOAD = 1'b1
  } wb_source_e;

  function automatic wb_source_e wb_other_source(input wb_source_e src);
    return (src == WB_SRC_ALU) ? WB_SRC_LOAD : WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/cpu_wb_arbiter.sv
// Two-way round-robin arbiter between the ALU and load result sources.
module cpu_wb_arbiter
  import cpu_pkg::*;
(
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       alu_valid_in,
  input  logic       load_valid_in,
  input  logic       handshake_in,
  output wb_source_e grant_out
);

  wb_source_e priority_q;
  wb_source_e priority_d;
  wb_source_e grant_s;

  // Grant selection: a lone requester wins, otherwise the favoured source.
  always_comb begin
    grant_s = priority_q;
    if (alu_valid_in && !load_valid_in) begin
      grant_s = WB_SRC_ALU;
    end else if (load_valid_in && !alu_valid_in) begin
      grant_s = WB_SRC_LOAD;
    end else begin
      grant_s = priority_q;
    end
  end

  // Favour the other source only after a real transfer.
  always_comb begin
    if (handshake_in) begin
      priority_d = wb_other_source(grant_s);
    end else begin
      priority_d = priority_q;
    end
  end

  // Round-robin pointer register; ALU is favoured out of reset.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      priority_q <= WB_SRC_ALU;
    end else begin
      priority_q <= priority_d;
    end
  end

  assign grant_out = grant_s;

endmodule

// File: rtl/cpu_writeback_queue.sv
// Writeback queue: arbitrates ALU/load results into an in-order FIFO that drains
// onto the register file write port and exports a pending-write mask for decode.
module cpu_writeback_queue
  import cpu_pkg::*;
#(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int QUEUE_DEPTH         = 4,
  localparam int AW = $clog2(NUMBER_OF_REGISTERS),
  localparam int CW = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                           clock_in,
  input  logic                           reset_in,
  input  logic                           flush_in,
  input  logic                           alu_valid_in,
  output logic                           alu_ready_out,
  input  logic [AW-1:0]                  alu_address_in,
  input  logic signed [BUS_WIDTH:0]      alu_data_in,
  input  logic                           load_valid_in,
  output logic                           load_ready_out,
  input  logic [AW-1:0]                  load_address_in,
  input  logic signed [BUS_WIDTH:0]      load_data_in,
  input  logic                           drain_enable_in,
  output logic                           write_enable_out,
  output logic [AW-1:0]                  write_register_address_out,
  output logic signed [BUS_WIDTH:0]      write_data_out,
  output logic [NUMBER_OF_REGISTERS-1:0] pending_mask_out,
  output logic [CW-1:0]                  queue_count_out
);

  localparam int PW = $clog2(QUEUE_DEPTH);

  logic [AW-1:0]             addr_q [QUEUE_DEPTH];
  logic signed [BUS_WIDTH:0] data_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]    valid_q;
  logic [QUEUE_DEPTH-1:0]    valid_d;
  logic [PW-1:0]             wr_ptr_q;
  logic [PW-1:0]             wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q;
  logic [PW-1:0]             rd_ptr_d;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;

  wb_source_e                grant_s;
  logic                      full_s;
  logic                      empty_s;
  logic                      accept_ok_s;
  logic                      alu_fire_s;
  logic                      load_fire_s;
  logic                      handshake_s;
  logic                      enq_s;
  logic                      deq_s;
  logic [AW-1:0]             in_addr_s;
  logic signed [BUS_WIDTH:0] in_data_s;
  logic [NUMBER_OF_REGISTERS-1:0] mask_s;

  cpu_wb_arbiter u_arbiter (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .alu_valid_in  (alu_valid_in),
    .load_valid_in (load_valid_in),
    .handshake_in  (handshake_s),
    .grant_out     (grant_s)
  );

  assign full_s  = (count_q == CW'(QUEUE_DEPTH));
  assign empty_s = (count_q == CW'(0));

  // Readies are forced low while reset is held so nothing is accepted mid-reset.
  assign accept_ok_s    = reset_in && !full_s && !flush_in;
  assign alu_ready_out  = accept_ok_s && (grant_s == WB_SRC_ALU);
  assign load_ready_out = accept_ok_s && (grant_s == WB_SRC_LOAD);
  assign alu_fire_s     = alu_valid_in && alu_ready_out;
  assign load_fire_s    = load_valid_in && load_ready_out;
  assign handshake_s    = alu_fire_s || load_fire_s;

  // Select the granted source's payload.
  always_comb begin
    if (grant_s == WB_SRC_LOAD) begin
      in_addr_s = load_address_in;
      in_data_s = load_data_in;
    end else begin
      in_addr_s = alu_address_in;
      in_data_s = alu_data_in;
    end
  end

  // Writes to r0 complete the handshake but never occupy a slot.
  assign enq_s = handshake_s && (in_addr_s != AW'(0));
  assign deq_s = write_enable_out && !flush_in;

  assign write_enable_out           = !empty_s && drain_enable_in;
  assign write_register_address_out = addr_q[rd_ptr_q];
  assign write_data_out             = data_q[rd_ptr_q];
  assign queue_count_out            = count_q;

  // Queue bookkeeping next-state; flush discards everything.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (deq_s) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (enq_s) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload storage, written at the tail on enqueue.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (enq_s && !flush_in) begin
      addr_q[wr_ptr_q] <= in_addr_s;
      data_q[wr_ptr_q] <= in_data_s;
    end else begin
      addr_q[wr_ptr_q] <= addr_q[wr_ptr_q];
      data_q[wr_ptr_q] <= data_q[wr_ptr_q];
    end
  end

  // Pending mask includes the head entry even in the cycle it is written.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (valid_q[i]) begin
        mask_s[addr_q[i]] = 1'b1;
      end else begin
        mask_s = mask_s;
      end
    end
  end

  assign pending_mask_out = mask_s;

endmodule

// File: tb/tb_cpu_writeback_queue.sv
// Directed self-checking bench for cpu_writeback_queue.
module tb_cpu_writeback_queue;

  logic              clk_s = 1'b0;
  logic              rst_n_s;
  logic              flush_s;
  logic              alu_valid_s;
  logic              alu_ready_s;
  logic [4:0]        alu_addr_s;
  logic signed [7:0] alu_data_s;
  logic              load_valid_s;
  logic              load_ready_s;
  logic [4:0]        load_addr_s;
  logic signed [7:0] load_data_s;
  logic              drain_s;
  logic              we_s;
  logic [4:0]        waddr_s;
  logic signed [7:0] wdata_s;
  logic [31:0]       mask_s;
  logic [2:0]        count_s;

  int checks = 0;
  int failures = 0;

  cpu_writeback_queue #(.NUMBER_OF_REGISTERS(32), .QUEUE_DEPTH(4)) dut (
    .clock_in                   (clk_s),
    .reset_in                   (rst_n_s),
    .flush_in                   (flush_s),
    .alu_valid_in               (alu_valid_s),
    .alu_ready_out              (alu_ready_s),
    .alu_address_in             (alu_addr_s),
    .alu_data_in                (alu_data_s),
    .load_valid_in              (load_valid_s),
    .load_ready_out             (load_ready_s),
    .load_address_in            (load_addr_s),
    .load_data_in               (load_data_s),
    .drain_enable_in            (drain_s),
    .write_enable_out           (we_s),
    .write_register_address_out (waddr_s),
    .write_data_out             (wdata_s),
    .pending_mask_out           (mask_s),
    .queue_count_out            (count_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic idle_inputs();
    flush_s      = 1'b0;
    alu_valid_s  = 1'b0;
    alu_addr_s   = 5'd0;
    alu_data_s   = 8'sd0;
    load_valid_s = 1'b0;
    load_addr_s  = 5'd0;
    load_data_s  = 8'sd0;
    drain_s      = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_s = 1'b0;
    repeat (2) @(posedge clk_s);
    #1;
    rst_n_s = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_s      = 1'b0;
    alu_valid_s  = 1'b1;
    alu_addr_s   = 5'd6;
    load_valid_s = 1'b1;
    load_addr_s  = 5'd7;
    repeat (3) tick();
    checks++;
    if (alu_ready_s !== 1'b0 || load_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got alu=%b load=%b want 0/0", alu_ready_s, load_ready_s);
    end
    checks++;
    if (we_s !== 1'b0 || mask_s !== 32'd0 || count_s !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b mask=%h count=%0d want 0", we_s, mask_s, count_s);
    end
    idle_inputs();
    rst_n_s = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    alu_valid_s = 1'b1;
    alu_addr_s  = 5'd5;
    alu_data_s  = 8'sh7F;
    #1;
    checks++;
    if (alu_ready_s !== 1'b1 || we_s !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got ready=%b we=%b want 1/0", alu_ready_s, we_s);
    end
    tick();
    alu_valid_s = 1'b0;
    #1;
    checks++;
    if (we_s !== 1'b1 || waddr_s !== 5'd5 || wdata_s !== 8'sh7F) begin
      failures++;
      $display("FAIL single_write got we=%b addr=%0d data=%h want 1/5/7f", we_s, waddr_s, wdata_s);
    end
    checks++;
    if (mask_s !== 32'h0000_0020 || count_s !== 3'd1) begin
      failures++;
      $display("FAIL single_mask got mask=%h count=%0d want 00000020/1", mask_s, count_s);
    end
    tick();
    checks++;
    if (we_s !== 1'b0 || mask_s !== 32'd0 || count_s !== 3'd0) begin
      failures++;
      $display("FAIL single_clear got we=%b mask=%h count=%0d want 0/0/0", we_s, mask_s, count_s);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_addr [8];
    logic [7:0] exp_data [8];
    int a_idx;
    int l_idx;
    int n_wr;
    int cyc;
    logic exp_alu;
    logic both;
    exp_addr = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
    exp_data = '{8'h11, 8'h91, 8'h12, 8'h92, 8'h13, 8'h93, 8'h14, 8'h94};
    do_reset();
    a_idx   = 0;
    l_idx   = 0;
    n_wr    = 0;
    cyc     = 0;
    exp_alu = 1'b1;
    while ((a_idx < 4 || l_idx < 4 || n_wr < 8) && cyc < 30) begin
      alu_valid_s  = (a_idx < 4);
      alu_addr_s   = 5'(1 + a_idx);
      alu_data_s   = 8'(8'h11 + a_idx);
      load_valid_s = (l_idx < 4);
      load_addr_s  = 5'(9 + l_idx);
      load_data_s  = 8'(8'h91 + l_idx);
      #1;
      both = alu_valid_s && load_valid_s;
      if (both) begin
        checks++;
        if (alu_ready_s !== exp_alu || load_ready_s !== !exp_alu) begin
          failures++;
          $display("FAIL rr_grant cyc=%0d got alu=%b load=%b want alu=%b", cyc, alu_ready_s, load_ready_s, exp_alu);
        end
      end
      if (we_s === 1'b1) begin
        checks++;
        if (n_wr >= 8 || waddr_s !== exp_addr[n_wr] || wdata_s !== exp_data[n_wr]) begin
          failures++;
          $display("FAIL rr_order idx=%0d got addr=%0d data=%h", n_wr, waddr_s, wdata_s);
        end
        n_wr++;
      end
      if (alu_valid_s && alu_ready_s) begin
        a_idx++;
        exp_alu = 1'b0;
      end else if (load_valid_s && load_ready_s) begin
        l_idx++;
        exp_alu = 1'b1;
      end
      tick();
      cyc++;
    end
    idle_inputs();
    checks++;
    if (n_wr != 8 || a_idx != 4 || l_idx != 4) begin
      failures++;
      $display("FAIL rr_done got writes=%0d alu=%0d load=%0d want 8/4/4", n_wr, a_idx, l_idx);
    end
  endtask

  task automatic test_backpressure();
    int n_wr;
    int cyc;
    int peak;
    logic sent5;
    do_reset();
    drain_s = 1'b0;
    peak    = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid_s = 1'b1;
      alu_addr_s  = 5'(20 + i);
      alu_data_s  = 8'(8'hA0 + i);
      #1;
      checks++;
      if (alu_ready_s !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept i=%0d got ready=%b want 1", i, alu_ready_s);
      end
      tick();
    end
    alu_addr_s = 5'd24;
    alu_data_s = 8'hA4;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (alu_ready_s !== 1'b0 || count_s !== 3'd4 || we_s !== 1'b0 || waddr_s !== 5'd20) begin
        failures++;
        $display("FAIL bp_full got ready=%b count=%0d we=%b head=%0d want 0/4/0/20", alu_ready_s, count_s, we_s, waddr_s);
      end
      tick();
    end
    drain_s = 1'b1;
    n_wr    = 0;
    cyc     = 0;
    sent5   = 1'b0;
    while (n_wr < 5 && cyc < 15) begin
      alu_valid_s = !sent5;
      #1;
      if (int'(count_s) > peak) peak = int'(count_s);
      if (cyc == 0) begin
        checks++;
        if (alu_ready_s !== 1'b0) begin
          failures++;
          $display("FAIL bp_full_drain got ready=%b want 0", alu_ready_s);
        end
      end
      if (we_s === 1'b1) begin
        checks++;
        if (waddr_s !== 5'(20 + n_wr) || wdata_s !== 8'(8'hA0 + n_wr)) begin
          failures++;
          $display("FAIL bp_order idx=%0d got addr=%0d data=%h", n_wr, waddr_s, wdata_s);
        end
        n_wr++;
      end
      if (alu_valid_s && alu_ready_s) sent5 = 1'b1;
      tick();
      cyc++;
    end
    idle_inputs();
    checks++;
    if (n_wr != 5 || peak != 4 || count_s !== 3'd0) begin
      failures++;
      $display("FAIL bp_done got writes=%0d peak=%0d count=%0d want 5/4/0", n_wr, peak, count_s);
    end
  endtask

  task automatic test_r0_discard();
    do_reset();
    alu_valid_s = 1'b1;
    alu_addr_s  = 5'd0;
    alu_data_s  = 8'sh55;
    #1;
    checks++;
    if (alu_ready_s !== 1'b1) begin
      failures++;
      $display("FAIL r0_ready got %b want 1", alu_ready_s);
    end
    tick();
    alu_valid_s = 1'b0;
    #1;
    checks++;
    if (we_s !== 1'b0 || mask_s !== 32'd0 || count_s !== 3'd0) begin
      failures++;
      $display("FAIL r0_discard got we=%b mask=%h count=%0d want 0/0/0", we_s, mask_s, count_s);
    end
    alu_valid_s  = 1'b1;
    alu_addr_s   = 5'd6;
    load_valid_s = 1'b1;
    load_addr_s  = 5'd7;
    #1;
    checks++;
    if (load_ready_s !== 1'b1 || alu_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL r0_rr_advance got alu=%b load=%b want 0/1", alu_ready_s, load_ready_s);
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_flush();
    do_reset();
    drain_s     = 1'b0;
    alu_valid_s = 1'b1;
    alu_addr_s  = 5'd3;
    alu_data_s  = 8'sh01;
    tick();
    alu_data_s  = 8'sh80;
    tick();
    alu_valid_s = 1'b0;
    #1;
    checks++;
    if (count_s !== 3'd2 || mask_s !== 32'h0000_0008) begin
      failures++;
      $display("FAIL flush_fill got count=%0d mask=%h want 2/00000008", count_s, mask_s);
    end
    drain_s = 1'b1;
    #1;
    checks++;
    if (we_s !== 1'b1 || waddr_s !== 5'd3 || wdata_s !== 8'sh01) begin
      failures++;
      $display("FAIL flush_first got we=%b addr=%0d data=%h want 1/3/01", we_s, waddr_s, wdata_s);
    end
    tick();
    drain_s     = 1'b0;
    flush_s     = 1'b1;
    alu_valid_s = 1'b1;
    alu_addr_s  = 5'd9;
    #1;
    checks++;
    if (mask_s !== 32'h0000_0008 || we_s !== 1'b0 || alu_ready_s !== 1'b0 || wdata_s !== 8'sh80) begin
      failures++;
      $display("FAIL flush_cycle got mask=%h we=%b ready=%b data=%h want 00000008/0/0/80", mask_s, we_s, alu_ready_s, wdata_s);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count_s !== 3'd0 || mask_s !== 32'd0 || we_s !== 1'b0) begin
      failures++;
      $display("FAIL flush_after got count=%0d mask=%h we=%b want 0/0/0", count_s, mask_s, we_s);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drain_s     = 1'b0;
    alu_valid_s = 1'b1;
    alu_addr_s  = 5'd8;
    alu_data_s  = 8'sh3C;
    tick();
    alu_addr_s  = 5'd9;
    tick();
    alu_valid_s = 1'b0;
    drain_s     = 1'b1;
    #1;
    checks++;
    if (we_s !== 1'b1 || count_s !== 3'd2 || mask_s !== 32'h0000_0300) begin
      failures++;
      $display("FAIL areset_pre got we=%b count=%0d mask=%h want 1/2/00000300", we_s, count_s, mask_s);
    end
    rst_n_s = 1'b0;
    #1;
    checks++;
    if (we_s !== 1'b0 || count_s !== 3'd0 || mask_s !== 32'd0 || alu_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL areset_now got we=%b count=%0d mask=%h ready=%b want 0", we_s, count_s, mask_s, alu_ready_s);
    end
    tick();
    rst_n_s = 1'b1;
    tick();
    checks++;
    if (we_s !== 1'b0 || count_s !== 3'd0) begin
      failures++;
      $display("FAIL areset_after got we=%b count=%0d want 0/0", we_s, count_s);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n_s = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_backpressure();
    test_r0_discard();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
